// File: rtl/ksa_engine.sv
// ksa_engine: RC4 key-scheduling engine driving an external single-port
// S-box RAM with one-cycle read latency. A run first writes the identity
// permutation, then performs the key-dependent swap pass, six cycles per i.
module ksa_engine #(
    parameter int DATA_W    = 8,
    parameter int KEY_BYTES = 3
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [KEY_BYTES*DATA_W-1:0]   secret_key,
    output logic [DATA_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic                          mem_wren,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          busy,
    output logic                          done
);

    // Key index width; at least one bit so a single-symbol key still has a counter.
    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [DATA_W-1:0] I_LAST = {DATA_W{1'b1}};
    localparam logic [KW-1:0]     K_LAST = KW'(KEY_BYTES - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_RD_I  = 3'd2;
    localparam logic [2:0] ST_GET_I = 3'd3;
    localparam logic [2:0] ST_RD_J  = 3'd4;
    localparam logic [2:0] ST_GET_J = 3'd5;
    localparam logic [2:0] ST_WR_I  = 3'd6;
    localparam logic [2:0] ST_WR_J  = 3'd7;

    logic [2:0]                      state_reg;
    logic [DATA_W-1:0]               i_reg;
    logic [DATA_W-1:0]               j_reg;
    logic [DATA_W-1:0]               si_reg;
    logic [DATA_W-1:0]               sj_reg;
    logic [DATA_W-1:0]               wdata_hold_reg;
    logic [KW-1:0]                   k_reg;
    logic                            done_reg;
    logic [KEY_BYTES*DATA_W-1:0]     key_reg;

    logic [DATA_W-1:0]               key_sym [KEY_BYTES];
    logic [DATA_W-1:0]               key_cur;
    logic [DATA_W-1:0]               j_next;
    logic [KW-1:0]                   k_next;

    // Split the captured key into symbols; symbol 0 sits in the top bits.
    generate
        for (genvar gi = 0; gi < KEY_BYTES; gi++) begin : g_key_sym
            assign key_sym[gi] = key_reg[(KEY_BYTES-1-gi)*DATA_W +: DATA_W];
        end
    endgenerate

    // Select the key symbol for the current k without relying on index width.
    always_comb begin
        key_cur = '0;
        for (int n = 0; n < KEY_BYTES; n++) begin
            if (k_reg == KW'(n)) begin
                key_cur = key_sym[n];
            end
        end
    end

    assign j_next = j_reg + mem_rdata + key_cur;
    assign k_next = (k_reg == K_LAST) ? '0 : k_reg + 1'b1;

    // Decode the RAM port from the registered state; wdata holds when not writing.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = wdata_hold_reg;
        mem_wren  = 1'b0;
        case (state_reg)
            ST_INIT: begin
                mem_addr  = i_reg;
                mem_wdata = i_reg;
                mem_wren  = 1'b1;
            end
            ST_RD_I, ST_GET_I: mem_addr = i_reg;
            ST_RD_J, ST_GET_J: mem_addr = j_reg;
            ST_WR_I: begin
                mem_addr  = i_reg;
                mem_wdata = sj_reg;
                mem_wren  = 1'b1;
            end
            ST_WR_J: begin
                mem_addr  = j_reg;
                mem_wdata = si_reg;
                mem_wren  = 1'b1;
            end
            default: mem_addr = '0;
        endcase
    end

    assign busy = (state_reg != ST_IDLE);
    assign done = done_reg;

    // Sequencer: identity fill, then read-i / read-j / write-both per index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            i_reg          <= '0;
            j_reg          <= '0;
            k_reg          <= '0;
            si_reg         <= '0;
            sj_reg         <= '0;
            wdata_hold_reg <= '0;
            done_reg       <= 1'b0;
            key_reg        <= '0;
        end else begin
            if (mem_wren) begin
                wdata_hold_reg <= mem_wdata;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        key_reg   <= secret_key;
                        i_reg     <= '0;
                        j_reg     <= '0;
                        k_reg     <= '0;
                        done_reg  <= 1'b0;
                        state_reg <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    // i wraps to 0 naturally after the last identity write.
                    i_reg <= i_reg + 1'b1;
                    if (i_reg == I_LAST) begin
                        state_reg <= ST_RD_I;
                    end
                end
                ST_RD_I:  state_reg <= ST_GET_I;
                ST_GET_I: begin
                    si_reg    <= mem_rdata;
                    j_reg     <= j_next;
                    state_reg <= ST_RD_J;
                end
                ST_RD_J:  state_reg <= ST_GET_J;
                ST_GET_J: begin
                    sj_reg    <= mem_rdata;
                    state_reg <= ST_WR_I;
                end
                ST_WR_I:  state_reg <= ST_WR_J;
                ST_WR_J: begin
                    i_reg <= i_reg + 1'b1;
                    if (i_reg == I_LAST) begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        k_reg     <= k_next;
                        state_reg <= ST_RD_I;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ksa_engine.sv
// Directed bench for ksa_engine: one 8-bit/3-symbol instance plus two 2-bit
// instances, each with a behavioural one-cycle-latency RAM.
module tb_ksa_engine;

    logic clk;
    logic reset_n;

    // 8-bit, 3-symbol instance
    logic        start8;
    logic [23:0] secret_key8;
    logic [7:0]  addr8, wdata8, rdata8;
    logic        wren8, busy8, done8;
    logic [7:0]  ram8 [256];
    logic [7:0]  exp8 [256];
    int          wr_cnt8;

    // 2-bit instances: index 0 has one key symbol, index 1 has two
    logic [1:0]  start_s, busy_s, done_s, wren_s;
    logic [1:0]  key_a;
    logic [3:0]  key_b;
    logic [1:0]  addr_a, wdata_a, rdata_a, addr_b, wdata_b, rdata_b;
    logic [1:0]  ram_a [4];
    logic [1:0]  ram_b [4];

    int n_vec;
    int n_err;

    ksa_engine #(.DATA_W(8), .KEY_BYTES(3)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .secret_key(secret_key8),
        .mem_addr(addr8), .mem_wdata(wdata8), .mem_wren(wren8), .mem_rdata(rdata8),
        .busy(busy8), .done(done8)
    );

    ksa_engine #(.DATA_W(2), .KEY_BYTES(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_s[0]), .secret_key(key_a),
        .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_wren(wren_s[0]), .mem_rdata(rdata_a),
        .busy(busy_s[0]), .done(done_s[0])
    );

    ksa_engine #(.DATA_W(2), .KEY_BYTES(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_s[1]), .secret_key(key_b),
        .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_wren(wren_s[1]), .mem_rdata(rdata_b),
        .busy(busy_s[1]), .done(done_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAMs: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (wren8) begin
            ram8[addr8] <= wdata8;
            wr_cnt8     <= wr_cnt8 + 1;
        end
        rdata8 <= ram8[addr8];
        if (wren_s[0]) ram_a[addr_a] <= wdata_a;
        rdata_a <= ram_a[addr_a];
        if (wren_s[1]) ram_b[addr_b] <= wdata_b;
        rdata_b <= ram_b[addr_b];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Software RC4 KSA for a 3-byte key into exp8.
    task automatic ksa_model(input logic [23:0] key);
        logic [7:0] j;
        logic [7:0] t;
        logic [7:0] kb [3];
        kb[0] = key[23:16];
        kb[1] = key[15:8];
        kb[2] = key[7:0];
        for (int i = 0; i < 256; i++) exp8[i] = 8'(i);
        j = 8'd0;
        for (int i = 0; i < 256; i++) begin
            j       = j + exp8[i] + kb[i % 3];
            t       = exp8[i];
            exp8[i] = exp8[j];
            exp8[j] = t;
        end
    endtask

    task automatic compare8(input string tag);
        int d;
        d = 0;
        for (int i = 0; i < 256; i++) if (ram8[i] !== exp8[i]) d++;
        check(tag, d, 0);
    endtask

    // Full 8-bit run from IDLE; optionally disturbs start/key mid-run.
    task automatic run8(input logic [23:0] key, input bit disturb);
        int busy_cyc, wr_seen, wr_bad;
        logic [31:0] ws;
        secret_key8 = key;
        start8      = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("done_drops_after_start", done8, 0);
        busy_cyc = 0; wr_seen = 0; wr_bad = 0;
        for (int cyc = 0; cyc < 2000 && busy8; cyc++) begin
            busy_cyc++;
            if (wren8 && wr_seen < 256) begin
                ws = wr_seen;
                if (addr8 !== ws[7:0] || wdata8 !== ws[7:0]) wr_bad++;
                wr_seen++;
            end
            if (disturb && cyc == 500) begin
                start8      = 1'b1;
                secret_key8 = ~key;
            end
            if (disturb && cyc == 501) start8 = 1'b0;
            @(posedge clk); #1;
        end
        check("busy_cycles", busy_cyc, 1792);
        check("init_write_pattern", wr_bad, 0);
        check("done_with_busy_fall", done8, 1);
        $display("run key=%06h disturb=%0d busy_cycles=%0d", key, disturb, busy_cyc);
    endtask

    task automatic run_small(input int sel, output int busy_cyc);
        start_s[sel] = 1'b1;
        @(posedge clk); #1;
        start_s[sel] = 1'b0;
        busy_cyc = 0;
        for (int c = 0; c < 100 && busy_s[sel]; c++) begin
            busy_cyc++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int snap, bc;
        n_vec = 0; n_err = 0; wr_cnt8 = 0;
        reset_n = 1'b1; start8 = 1'b0; secret_key8 = 24'h0;
        start_s = 2'b00; key_a = 2'd0; key_b = {2'd1, 2'd2};

        // Reset held low: all outputs quiescent
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", addr8, 0);
        check("rst_wdata", wdata8, 0);
        check("rst_wren", wren8, 0);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        reset_n = 1'b1;

        // Reset asserted mid-INIT: outputs clear immediately, no more writes
        secret_key8 = 24'h000000;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (40) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("async_rst_busy", busy8, 0);
        check("async_rst_wren", wren8, 0);
        check("async_rst_addr", addr8, 0);
        check("async_rst_wdata", wdata8, 0);
        snap = wr_cnt8;
        repeat (3) @(posedge clk);
        #1;
        check("no_writes_in_reset", wr_cnt8, snap);
        reset_n = 1'b1;

        // Clean run after the aborted one, zero key
        run8(24'h000000, 1'b0);
        ksa_model(24'h000000);
        compare8("image_key_000000");

        // Run with start pulse and key change while busy
        run8(24'h4B6579, 1'b1);
        ksa_model(24'h4B6579);
        compare8("image_key_4b6579_disturbed");

        // Back-to-back run started in the first IDLE cycle after done
        run8(24'hA53C0F, 1'b0);
        ksa_model(24'hA53C0F);
        compare8("image_key_a53c0f");

        // 2-bit, one-symbol key 0: expected [0,2,3,1]
        run_small(0, bc);
        check("small_k1_busy_cycles", bc, 28);
        check("small_k1_done", done_s[0], 1);
        check("small_k1_image", {ram_a[0], ram_a[1], ram_a[2], ram_a[3]}, 8'b00_10_11_01);
        $display("run small k1 busy_cycles=%0d", bc);

        // 2-bit, key {1,2}: expected [0,3,2,1]
        run_small(1, bc);
        check("small_k2_busy_cycles", bc, 28);
        check("small_k2_done", done_s[1], 1);
        check("small_k2_image", {ram_b[0], ram_b[1], ram_b[2], ram_b[3]}, 8'b00_11_10_01);
        $display("run small k2 busy_cycles=%0d", bc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ksa_engine.md
# ksa_engine

Parametrised RC4 key-scheduling engine that drives an external single-port S-box RAM through its full key-scheduling pass. On a `start` handshake it fills the array with the identity permutation (S[i] = i), then runs the key-dependent shuffle (j = j + S[i] + key[i mod KEY_BYTES]; swap S[i], S[j]). It reports completion with `done`. It sits between the top-level control logic and the `s_memory` instance, ahead of the PRGA/decrypt stage.

## Interface
Parameters:
- DATA_W, 8: S-box entry width and address width; array depth N = 2^DATA_W.
- KEY_BYTES, 3: number of key symbols; each symbol is DATA_W bits wide.

Ports:
- clk  in  1  system clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a full KSA run; sampled only in IDLE.
- secret_key  in  KEY_BYTES*DATA_W  key; symbol 0 is the most-significant DATA_W bits; captured on accepted start.
- mem_addr  out  DATA_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_wren  out  1  RAM write enable.
- mem_rdata  in  DATA_W  RAM read data (q).
- busy  out  1  high while a run is in progress.
- done  out  1  high after a completed run until the next accepted start.

## Operation
- RAM model: synchronous, one-cycle read latency. The address presented in cycle t is sampled at the edge ending t, and `mem_rdata` is valid throughout cycle t+1. Writes commit at the edge ending the cycle with `mem_wren` = 1.
- Registers: i, j (DATA_W bits each), k (key index, 0..KEY_BYTES-1), si, sj, and the captured key.
- All arithmetic is modulo 2^DATA_W, by truncation. k is a wrapping counter (no divider): k = 0 when i = 0, and k wraps to 0 after KEY_BYTES-1.
- State machine:
  - IDLE: outputs quiescent. On start = 1: capture key, i ← 0, j ← 0, k ← 0, done ← 0, go to INIT.
  - INIT: addr = i, wdata = i, wren = 1. i increments each cycle. After i = N-1: i ← 0, go to RD_I.
  - RD_I: addr = i, wren = 0.
  - GET_I: si ← mem_rdata; j ← j + mem_rdata + key[k].
  - RD_J: addr = j (the updated value).
  - GET_J: sj ← mem_rdata.
  - WR_I: addr = i, wdata = sj, wren = 1.
  - WR_J: addr = j, wdata = si, wren = 1. If i = N-1, go to IDLE with done ← 1. Otherwise i ← i+1, advance k, go to RD_I.
- i = j: the two writes target the same word with equal data; the result is correct with no special case.
- start while busy: ignored. secret_key changes after capture: no effect on the run in progress.
- When wren = 0, mem_wdata holds its last value; its value is don't-care.

## Timing
- Reset: asynchronous assertion forces IDLE at any point, including mid-INIT or mid-shuffle. Reset values: i = j = k = 0, mem_addr = 0, mem_wdata = 0, mem_wren = 0, busy = 0, done = 0. RAM contents are left partially updated; the next run rewrites the entire array.
- Start handshake:
  - start is sampled at edge E in IDLE.
  - First INIT write (addr 0) occurs in cycle E+1.
  - busy = 1 from cycle E+1 through the final WR_J cycle.
- Latency: INIT takes N cycles, shuffle takes 6 cycles per i (6N total). busy is high for exactly 7N cycles; N = 256 gives 1792 cycles.
- done: rises in the cycle after the last WR_J, together with the return to IDLE. It holds until the next accepted start or reset.
- Back-to-back runs: start asserted in the first IDLE cycle after done is accepted, and the sequence repeats identically.
- mem_addr, mem_wdata and mem_wren are valid in the same cycle as the state that defines them; they may be decoded combinationally from the registered state.

## Test plan
- Reset: hold reset_n = 0 -> all outputs 0. Assert reset_n = 0 during INIT of a run -> outputs return to 0 asynchronously with no further writes. Then start with DATA_W = 8, key 24'h000000 -> identical RAM image to a clean run.
- DATA_W = 2, KEY_BYTES = 1, key = 2'd0, start -> RAM final [0,2,3,1]. Covers the i = j no-op swaps at i = 0 and i = 1.
- DATA_W = 2, KEY_BYTES = 2, key = {2'd1,2'd2} -> RAM final [0,3,2,1]. Covers k wrap and j mod-4 wrap (j = 6→2 and 4→0).
- DATA_W = 8, KEY_BYTES = 3, start -> busy high exactly 1792 cycles. First 256 write cycles write addr = data = 0..255. done rises the cycle busy falls.
- While busy: pulse start and change secret_key -> no restart, final RAM matches the originally captured key, total latency unchanged.
- After done: start again with a different key -> done drops the next cycle and a full 7N-cycle run repeats. Final image matches the software RC4 KSA for that key.
